// File: rtl/arbitro_memoria_dados.sv
// arbitro_memoria_dados: two-port arbiter / access sequencer for the
// single-port data memory (registered address, one-cycle read latency).
// Serves the CPU load/store path and a host/debug port one access at a time.
// Optional feature: define ARBITRO_RR_EN for round-robin tie-breaking;
// otherwise the CPU has fixed priority on simultaneous requests.
module arbitro_memoria_dados #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Cpu_req,
  input  logic              Cpu_we,
  input  logic [ADDR_W-1:0] Cpu_addr,
  input  logic [DATA_W-1:0] Cpu_wdata,
  output logic              Cpu_ack,
  output logic [DATA_W-1:0] Cpu_rdata,
  input  logic              Host_req,
  input  logic              Host_we,
  input  logic [ADDR_W-1:0] Host_addr,
  input  logic [DATA_W-1:0] Host_wdata,
  output logic              Host_ack,
  output logic [DATA_W-1:0] Host_rdata,
  output logic [ADDR_W-1:0] Mem_address,
  output logic [DATA_W-1:0] Mem_data,
  output logic              Mem_wren,
  input  logic [DATA_W-1:0] Mem_q,
  output logic [1:0]        Grant
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_ACK
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CPU  = 2'b01;
  localparam logic [1:0] GNT_HOST = 2'b10;

  state_t              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                host_ack_q, host_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic                mem_wren_q, mem_wren_d;
  logic                cpu_wins;
`ifdef ARBITRO_RR_EN
  logic                last_host_q, last_host_d;
`endif

  // Next-state and registered-output computation for the access sequence.
  // The memory controls are registered on the IDLE->ACCESS edge so they are
  // valid for the whole ACCESS cycle; the write lands on the edge ending it.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    cpu_ack_d     = 1'b0;
    host_ack_d    = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;
    host_rdata_d  = host_rdata_q;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    mem_wren_d    = 1'b0;
    cpu_wins      = 1'b0;
`ifdef ARBITRO_RR_EN
    last_host_d   = last_host_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (Cpu_req || Host_req) begin
`ifdef ARBITRO_RR_EN
          // On a tie the port not served last wins.
          cpu_wins = Cpu_req && (!Host_req || last_host_q);
`else
          cpu_wins = Cpu_req;
`endif
          grant_d       = cpu_wins ? GNT_CPU : GNT_HOST;
          mem_address_d = cpu_wins ? Cpu_addr : Host_addr;
          mem_data_d    = cpu_wins ? Cpu_wdata : Host_wdata;
          mem_wren_d    = cpu_wins ? Cpu_we : Host_we;
          state_d       = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // mem_wren_q holds the granted port's we for this transaction.
        if (mem_wren_q) begin
          cpu_ack_d  = grant_q[0];
          host_ack_d = grant_q[1];
          state_d    = S_ACK;
        end else begin
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (grant_q[0]) cpu_rdata_d = Mem_q;
        if (grant_q[1]) host_rdata_d = Mem_q;
        cpu_ack_d  = grant_q[0];
        host_ack_d = grant_q[1];
        state_d    = S_ACK;
      end
      S_ACK: begin
`ifdef ARBITRO_RR_EN
        last_host_d = grant_q[1];
`endif
        grant_d = GNT_NONE;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = GNT_NONE;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; asynchronous reset clears any access in flight.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      grant_q       <= GNT_NONE;
      cpu_ack_q     <= 1'b0;
      host_ack_q    <= 1'b0;
      cpu_rdata_q   <= '0;
      host_rdata_q  <= '0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_wren_q    <= 1'b0;
`ifdef ARBITRO_RR_EN
      last_host_q   <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      cpu_ack_q     <= cpu_ack_d;
      host_ack_q    <= host_ack_d;
      cpu_rdata_q   <= cpu_rdata_d;
      host_rdata_q  <= host_rdata_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_wren_q    <= mem_wren_d;
`ifdef ARBITRO_RR_EN
      last_host_q   <= last_host_d;
`endif
    end
  end

  assign Cpu_ack     = cpu_ack_q;
  assign Cpu_rdata   = cpu_rdata_q;
  assign Host_ack    = host_ack_q;
  assign Host_rdata  = host_rdata_q;
  assign Mem_address = mem_address_q;
  assign Mem_data    = mem_data_q;
  assign Mem_wren    = mem_wren_q;
  assign Grant       = grant_q;

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Testbench for arbitro_memoria_dados with a behavioural 64x16 memory
// (registered address, write on rising edge when wren is high).
module tb_arbitro_memoria_dados;

  logic        Clock;
  logic        Reset;
  logic        Cpu_req, Cpu_we, Cpu_ack;
  logic [5:0]  Cpu_addr;
  logic [15:0] Cpu_wdata, Cpu_rdata;
  logic        Host_req, Host_we, Host_ack;
  logic [5:0]  Host_addr;
  logic [15:0] Host_wdata, Host_rdata;
  logic [5:0]  Mem_address;
  logic [15:0] Mem_data, Mem_q;
  logic        Mem_wren;
  logic [1:0]  Grant;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_cpu_rd, exp_host_rd;

  arbitro_memoria_dados #(.ADDR_W(6), .DATA_W(16)) dut (
    .Clock(Clock), .Reset(Reset),
    .Cpu_req(Cpu_req), .Cpu_we(Cpu_we), .Cpu_addr(Cpu_addr), .Cpu_wdata(Cpu_wdata),
    .Cpu_ack(Cpu_ack), .Cpu_rdata(Cpu_rdata),
    .Host_req(Host_req), .Host_we(Host_we), .Host_addr(Host_addr), .Host_wdata(Host_wdata),
    .Host_ack(Host_ack), .Host_rdata(Host_rdata),
    .Mem_address(Mem_address), .Mem_data(Mem_data), .Mem_wren(Mem_wren), .Mem_q(Mem_q),
    .Grant(Grant)
  );

  // Behavioural single-port memory.
  logic [15:0] mem [64];
  logic [5:0]  mem_addr_r;
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem_addr_r = '0;
  end
  always @(posedge Clock) begin
    if (Mem_wren) mem[Mem_address] <= Mem_data;
    mem_addr_r <= Mem_address;
  end
  assign Mem_q = mem[mem_addr_r];

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required finish before 200000");
    $fatal(1);
  end

  typedef struct {
    bit          host;
    bit          we;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input bit host, input bit req, input bit we,
                       input logic [5:0] addr, input logic [15:0] wdata);
    if (host) begin
      Host_req = req; Host_we = we; Host_addr = addr; Host_wdata = wdata;
    end else begin
      Cpu_req = req; Cpu_we = we; Cpu_addr = addr; Cpu_wdata = wdata;
    end
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    #3;
    Reset = 1'b0;
    exp_cpu_rd  = '0;
    exp_host_rd = '0;
    step();
  endtask

  // One complete single-port transaction, started from IDLE.
  task automatic do_txn(input vec_t v, input string tag);
    logic [1:0] g;
    logic       my_ack, other_ack;
    g = v.host ? 2'b10 : 2'b01;
    drive(v.host, 1'b1, v.we, v.addr, v.wdata);
    step(); // ACCESS
    chk({tag, "_access_wren"}, Mem_wren, v.we);
    chk({tag, "_access_addr"}, Mem_address, v.addr);
    if (v.we) chk({tag, "_access_data"}, Mem_data, v.wdata);
    chk({tag, "_access_grant"}, Grant, g);
    step(); // ACK (write) or WAIT (read)
    chk({tag, "_wren_low"}, Mem_wren, 1'b0);
    if (!v.we) begin
      chk({tag, "_wait_noack"}, {Cpu_ack, Host_ack}, 2'b00);
      step(); // ACK
      if (v.host) exp_host_rd = v.exp_rdata;
      else        exp_cpu_rd  = v.exp_rdata;
    end
    my_ack    = v.host ? Host_ack : Cpu_ack;
    other_ack = v.host ? Cpu_ack : Host_ack;
    chk({tag, "_ack"}, my_ack, 1'b1);
    chk({tag, "_other_ack"}, other_ack, 1'b0);
    chk({tag, "_cpu_rdata"}, Cpu_rdata, exp_cpu_rd);
    chk({tag, "_host_rdata"}, Host_rdata, exp_host_rd);
    chk({tag, "_ack_grant"}, Grant, g);
    drive(v.host, 1'b0, 1'b0, '0, '0);
    step(); // IDLE
    chk({tag, "_idle_ack"}, {Cpu_ack, Host_ack}, 2'b00);
    chk({tag, "_idle_grant"}, Grant, 2'b00);
  endtask

  initial begin
    int  cyc;
    int  host_acks;
    bit  exp_host_win;
    bit  rr_mode;
    vec_t v;

`ifdef ARBITRO_RR_EN
    rr_mode = 1'b1;
`else
    rr_mode = 1'b0;
`endif

    vecs[0] = '{host: 0, we: 1, addr: 6'h0A, wdata: 16'h1234, exp_rdata: 16'h0000};
    vecs[1] = '{host: 0, we: 0, addr: 6'h0A, wdata: 16'h0000, exp_rdata: 16'h1234};
    vecs[2] = '{host: 1, we: 1, addr: 6'h3F, wdata: 16'hBEEF, exp_rdata: 16'h0000};
    vecs[3] = '{host: 0, we: 0, addr: 6'h3F, wdata: 16'h0000, exp_rdata: 16'hBEEF};
    vecs[4] = '{host: 1, we: 0, addr: 6'h0A, wdata: 16'h0000, exp_rdata: 16'h1234};
    vecs[5] = '{host: 1, we: 1, addr: 6'h05, wdata: 16'h00AA, exp_rdata: 16'h0000};
    vecs[6] = '{host: 0, we: 1, addr: 6'h00, wdata: 16'hFFFF, exp_rdata: 16'h0000};
    vecs[7] = '{host: 1, we: 0, addr: 6'h00, wdata: 16'h0000, exp_rdata: 16'hFFFF};
    vecs[8] = '{host: 0, we: 0, addr: 6'h05, wdata: 16'h0000, exp_rdata: 16'h00AA};

    Reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    exp_cpu_rd  = '0;
    exp_host_rd = '0;
    #1;
    chk("reset_acks", {Cpu_ack, Host_ack}, 2'b00);
    chk("reset_rdata", {Cpu_rdata, Host_rdata}, 32'h0);
    chk("reset_mem", {Mem_wren, Mem_address, Mem_data}, 23'h0);
    chk("reset_grant", Grant, 2'b00);
    step();
    Reset = 1'b0;
    step();

    // Table-driven single-port transactions.
    for (int i = 0; i < 9; i++) begin
      do_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Simultaneous reads held for four transactions.
    pulse_reset();
    drive(1'b0, 1'b1, 1'b0, 6'h0A, '0);
    drive(1'b1, 1'b1, 1'b0, 6'h3F, '0);
    host_acks = 0;
    for (int t = 0; t < 4; t++) begin
      cyc = 0;
      while (!Cpu_ack && !Host_ack && cyc < 10) begin
        step();
        cyc++;
      end
      chk($sformatf("tie%0d_timeout", t), (cyc < 10), 1'b1);
      exp_host_win = rr_mode ? t[0] : 1'b0;
      chk($sformatf("tie%0d_winner", t), {Host_ack, Cpu_ack}, exp_host_win ? 2'b10 : 2'b01);
      if (Host_ack) begin
        host_acks++;
        chk($sformatf("tie%0d_host_rdata", t), Host_rdata, 16'hBEEF);
      end else begin
        chk($sformatf("tie%0d_cpu_rdata", t), Cpu_rdata, 16'h1234);
      end
      if (t == 3) begin
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
      end
      step();
    end
    chk("tie_host_ack_count", host_acks, rr_mode ? 2 : 0);
    step();

    // Reset during ACCESS of a host write: the write must not happen.
    drive(1'b1, 1'b1, 1'b1, 6'h05, 16'hFFFF);
    step(); // ACCESS
    chk("rst_access_wren", Mem_wren, 1'b1);
    #2;
    Reset = 1'b1;
    #1;
    chk("rst_wren_drop", Mem_wren, 1'b0);
    chk("rst_outputs", {Mem_address, Mem_data, Grant, Cpu_ack, Host_ack}, 26'h0);
    chk("rst_rdata", {Cpu_rdata, Host_rdata}, 32'h0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    exp_cpu_rd  = '0;
    exp_host_rd = '0;
    step();
    step();
    Reset = 1'b0;
    host_acks = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (Host_ack) host_acks++;
    end
    chk("rst_no_host_ack", host_acks, 0);
    v = '{host: 0, we: 0, addr: 6'h05, wdata: 16'h0000, exp_rdata: 16'h00AA};
    do_txn(v, "rst_readback");

    // Host drops req after grant; its ack still comes, then the CPU is served.
    drive(1'b1, 1'b1, 1'b1, 6'h10, 16'h5555);
    step(); // ACCESS, host granted
    chk("drop_grant_host", Grant, 2'b10);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    drive(1'b0, 1'b1, 1'b0, 6'h10, '0);
    step(); // ACK
    chk("drop_host_ack", {Host_ack, Cpu_ack}, 2'b10);
    step(); // IDLE
    chk("drop_idle", {Grant, Host_ack}, 3'b000);
    step(); // ACCESS for CPU
    chk("drop_cpu_granted", Grant, 2'b01);
    host_acks = 0;
    cyc = 0;
    while (!Cpu_ack && cyc < 10) begin
      step();
      cyc++;
      if (Host_ack) host_acks++;
    end
    chk("drop_cpu_ack_cycles", cyc, 2);
    chk("drop_cpu_rdata", Cpu_rdata, 16'h5555);
    chk("drop_no_extra_host_ack", host_acks, 0);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    step();
    chk("drop_final_idle", {Grant, Cpu_ack, Host_ack}, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arbitro_memoria_dados.md
# arbitro_memoria_dados

- Two-port arbiter and access sequencer for the single-port 64×16 synchronous data memory (`memoram_dados`, 1-cycle registered-address read latency).
- Shares the memory between two requesters:
  - the multicycle processor's load/store path (CPU port);
  - a host/debug port used by the FPGA board to preload or inspect data.
- Serializes the requests, drives the memory's address, data and write-enable, captures read data and returns a one-cycle acknowledge to the granted requester.

## Interface
Parameters:
- `ADDR_W`, default 6: memory address width (64 words).
- `DATA_W`, default 16: data word width.

Ports (one clock; reset is asynchronous and active-high):
- `Clock` in 1: sole clock, rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `Cpu_req` in 1: CPU access request; held high until `Cpu_ack`.
- `Cpu_we` in 1: 1 = write, 0 = read; stable while `Cpu_req` is high.
- `Cpu_addr` in ADDR_W: CPU word address.
- `Cpu_wdata` in DATA_W: CPU write data.
- `Cpu_ack` out 1: one-cycle completion pulse to the CPU.
- `Cpu_rdata` out DATA_W: CPU read data; valid while `Cpu_ack`=1, held until the next CPU read completes.
- `Host_req`, `Host_we`, `Host_addr`, `Host_wdata`, `Host_ack`, `Host_rdata`: identical semantics for the host port.
- `Mem_address` out ADDR_W: to memory `address`.
- `Mem_data` out DATA_W: to memory `data`.
- `Mem_wren` out 1: to memory `wren`.
- `Mem_q` in DATA_W: from memory `q`.
- `Grant` out 2: 00 none, 01 CPU, 10 host; current owner for observability.

## Operation
- FSM states: IDLE, ACCESS, WAIT, ACK.
- IDLE:
  - Samples both `req` inputs.
  - If any is high, latches the winner into a grant register and goes to ACCESS.
  - If none is high, stays in IDLE.
- ACCESS:
  - `Mem_address` and `Mem_data` are taken from the granted port's inputs.
  - `Mem_wren` = granted `we`.
  - Next state is ACK for a write, WAIT for a read.
- WAIT:
  - `Mem_q` is valid in this cycle.
  - It is loaded into the granted port's `rdata` register at the end of this cycle.
  - Next state is ACK.
- ACK:
  - The granted port's `ack` = 1 for exactly one cycle.
  - Next state is IDLE, and the grant register moves to "last granted".
- Outside ACCESS: `Mem_wren` = 0, and `Mem_address`/`Mem_data` hold the last driven values.
- Arbitration on simultaneous requests in IDLE follows the Configuration section.
- A request that stays high after its `ack` is treated as a new request in the following IDLE cycle.
- A requester changing `we`/`addr`/`wdata` while its `req` is high is illegal and the result is undefined. The bench checks that legal use never depends on it.
- A requester dropping `req` before `ack` does not abort an access already granted; the `ack` is still issued.
- The non-granted port's `ack` stays 0 and its `rdata` is unchanged for the entire transaction.

## Timing
- Reset values, applied asynchronously:
  - state IDLE, `Grant` = 00, last-granted = host;
  - both `ack` = 0, both `rdata` = 0;
  - `Mem_wren` = 0, `Mem_address` = 0, `Mem_data` = 0.
- Latency, counting from the edge that samples `req` in IDLE:
  - write: ACCESS at +1, `ack` during +2 (2 cycles);
  - read: ACCESS +1, WAIT +2, `ack` +3 (3 cycles).
- The memory write occurs on the rising edge that ends ACCESS.
- Back-to-back throughput: one write per 3 cycles or one read per 4 cycles, because IDLE is always visited.
- Reset asserted during ACCESS forces `Mem_wren` to 0 immediately. The write happens only if the ACCESS-ending edge came before reset assertion.
- A pending `ack` is lost on reset; requesters must reissue.
- A request arriving during ACCESS/WAIT/ACK waits; it is evaluated in the next IDLE cycle.

## Configuration
- `ARBITRO_RR_EN` defined: round-robin arbitration.
  - On simultaneous requests in IDLE, the port not granted last wins.
  - After reset, the CPU wins the first tie.
- `ARBITRO_RR_EN` undefined: fixed priority, CPU always wins ties.
  - The last-granted register is not implemented.
  - The host can starve under continuous CPU traffic.

## Test plan
- Reset, then CPU write addr 0x0A, data 0x1234 → `Mem_wren`=1 for exactly one cycle at +1 with `Mem_address`=0x0A, `Mem_data`=0x1234; `Cpu_ack` at +2; `Grant`=01 during the transaction.
- CPU read 0x0A after that write → `Cpu_ack` at +3 with `Cpu_rdata`=0x1234; `Host_rdata` remains 0.
- Host write 0x3F ← 0xBEEF, then CPU read 0x3F → `Cpu_rdata`=0xBEEF (wrap-top address).
- Both ports issue reads together and hold `req` for 4 transactions:
  - with RR: grants C,H,C,H;
  - without RR: grants C,C,C,C and `Host_ack` never asserts.
- `Reset` pulsed mid-ACCESS of a host write to 0x05 ← 0xFFFF, asserted before the clock edge → `Mem_wren` drops immediately, no `Host_ack`, a subsequent read of 0x05 returns the old value, and all outputs are at reset values.
- `Host_req` dropped one cycle after grant → `Host_ack` is still issued once; the arbiter returns to IDLE and the CPU is granted next.
